// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the fixed-point square-root block.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result width: half the radicand bits plus the extra fractional bits.
  function automatic int calc_qw(input int w, input int e);
    return (w / 2) + e;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: bring down two radicand bits,
// try subtracting (4*root + 1), keep the result only if non-negative.
module sqrt_step #(
  parameter int QW = 12
) (
  input  logic [QW+1:0] rem_i,
  input  logic [QW-1:0] root_i,
  input  logic [1:0]    pair_i,
  output logic [QW+1:0] rem_o,
  output logic [QW-1:0] root_o
);

  logic [QW+3:0] shifted;
  logic [QW+3:0] trial;
  logic [QW+3:0] diff;
  logic          ge;

  // Trial subtraction and root-bit decision.
  always_comb begin
    shifted = {rem_i, pair_i};
    trial   = {2'b00, root_i, 2'b01};
    diff    = shifted - trial;
    ge      = (shifted >= trial);
    rem_o   = (QW+2)'(ge ? diff : shifted);
    root_o  = (root_i << 1) | QW'(ge);
  end

endmodule

// File: rtl/fixed_sqrt.sv
// Sequential fixed-point square root, one result bit per cycle.
// Optional remainder output enabled by defining SQRT_REM_EN.
module fixed_sqrt
  import sqrt_pkg::*;
#(
  parameter  int W  = 12,
  parameter  int F  = 4,
  parameter  int E  = 6,
  localparam int QW = calc_qw(W, E)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a,
  output logic          ready,
  output logic          busy,
  output logic          valid,
  output logic [QW-1:0] q
`ifdef SQRT_REM_EN
  ,
  output logic [QW:0]   rem
`endif
);

  localparam int unsigned RW = 2 * QW;
  localparam int unsigned CW = $clog2(QW + 1);

  // Reject parameter sets the datapath cannot represent.
  if ((W < 2) || ((W % 2) != 0) || ((F % 2) != 0) || (F < 0) || (F > W) || (E < 0))
  begin : g_param_check
    $error("fixed_sqrt: illegal parameters W=%0d F=%0d E=%0d", W, F, E);
  end

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [RW-1:0]   rad_q, rad_d;
  logic [QW+1:0]   prem_q, prem_d;
  logic [QW-1:0]   root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [QW-1:0]   q_q, q_d;
`ifdef SQRT_REM_EN
  logic [QW:0]     rem_q, rem_d;
`endif

  logic            accept;
  logic            a_zero;
  logic            last;
  logic [QW+1:0]   step_rem;
  logic [QW-1:0]   step_root;

  sqrt_step #(.QW(QW)) u_step (
    .rem_i  (prem_q),
    .root_i (root_q),
    .pair_i (rad_q[RW-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a zero radicand skips the iteration phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = a_zero ? DONE : CALC;
      CALC:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs follow the upcoming state so they register with it.
  always_comb begin
    accept  = (state_q == IDLE) && start;
    a_zero  = (a == '0);
    last    = (state_q == CALC) && (cnt_q == CW'(QW - 1));
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == CALC) || (state_d == DONE);
    valid_d = (state_d == DONE);
  end

  // Datapath next values: load on accept, iterate in CALC, publish on the last step.
  always_comb begin
    rad_d  = rad_q;
    prem_d = prem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
`ifdef SQRT_REM_EN
    rem_d  = rem_q;
`endif
    if (accept) begin
      rad_d  = RW'(a) << (2 * E);
      prem_d = '0;
      root_d = '0;
      cnt_d  = '0;
      if (a_zero) begin
        q_d   = '0;
`ifdef SQRT_REM_EN
        rem_d = '0;
`endif
      end
    end else if (state_q == CALC) begin
      rad_d  = rad_q << 2;
      prem_d = step_rem;
      root_d = step_root;
      cnt_d  = cnt_q + CW'(1);
      if (last) begin
        q_d   = step_root;
`ifdef SQRT_REM_EN
        rem_d = (QW+1)'(step_rem);
`endif
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rad_q   <= '0;
      prem_q  <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
`ifdef SQRT_REM_EN
      rem_q   <= '0;
`endif
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      rad_q   <= rad_d;
      prem_q  <= prem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
`ifdef SQRT_REM_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign q     = q_q;
`ifdef SQRT_REM_EN
  assign rem   = rem_q;
`endif

endmodule

// File: doc/fixed_sqrt.md
FIXED_SQRT -- requirements
Module: fixed_sqrt

Interface
REQ-001 Parameter W, default 12, SHALL be the radicand width in bits; it SHALL be even and at least 2.
REQ-002 Parameter F, default 4, SHALL be the radicand fractional bits; it SHALL be even and at most W.
REQ-003 Parameter E, default 6, SHALL be the extra result fractional bits (E >= 0); derived QW = W/2 + E is the result width and QF = F/2 + E is the result fractional bits.
REQ-004 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 start  input  1  SHALL be the request strobe, sampled only while ready = 1.
REQ-007 a  input  W  SHALL be the unsigned radicand with F fractional bits.
REQ-008 ready  output  1  SHALL be high only in IDLE.
REQ-009 busy  output  1  SHALL be high in CALC and DONE.
REQ-010 valid  output  1  SHALL be a one-cycle pulse marking q (and rem) as new.
REQ-011 q  output  QW  SHALL be the unsigned root with QF fractional bits.
REQ-012 rem  output  QW+1  SHALL be the remainder, present only when SQRT_REM_EN is defined.

Function
REQ-013 The block SHALL compute q = floor(sqrt(R)) with integer R = a << 2E (width W+2E), exact with no rounding error beyond truncation.
REQ-014 The FSM SHALL have states IDLE, CALC, DONE: IDLE->CALC on start with a != 0; IDLE->DONE on start with a == 0; CALC->DONE after QW iterations; DONE->IDLE unconditionally.
REQ-015 On acceptance a SHALL be captured into an internal register; later changes of a SHALL not affect the result.
REQ-016 CALC SHALL resolve one result bit per cycle, MSB first, by restoring digit-by-digit iteration on a (QW+2)-bit partial remainder.
REQ-017 For a != 0 accepted at edge t, valid SHALL be high for exactly the cycle after edge t+QW+1 (latency QW+1 cycles).
REQ-018 For a == 0, the fast path SHALL produce q = 0 (and rem = 0) with valid in the cycle after edge t+1.
REQ-019 valid SHALL assert only in DONE; q and rem SHALL update on entry to DONE and hold until the next DONE.
REQ-020 start while busy = 1 SHALL be ignored with no queuing; start during the DONE cycle SHALL be ignored.
REQ-021 The iteration counter SHALL be $clog2(QW+1) bits wide and SHALL not wrap within one operation.
REQ-022 The maximum input 2^W-1 SHALL complete without overflow in q or rem.

Reset
REQ-023 rst = 1 at an edge SHALL force IDLE, ready = 1, busy = 0, valid = 0, q = 0, rem = 0, and clear the counter and partial remainder.
REQ-024 Reset asserted in CALC or DONE SHALL abort the operation with no valid pulse; start in the first cycle after reset release SHALL be accepted.

Configuration
REQ-025 Macro SQRT_REM_EN defined: port rem SHALL exist and equal R - q*q (0 <= rem <= 2q) at valid.
REQ-026 Macro SQRT_REM_EN undefined: port rem and its output register SHALL be absent; q timing SHALL be identical.

Structure
REQ-027 Package sqrt_pkg SHALL hold the state enum (IDLE, CALC, DONE) and a function returning QW from W and E.
REQ-028 One combinational sub-module sqrt_step (one restoring iteration: partial remainder, root-so-far in; next remainder, next root out) is natural; the FSM, counter and registers SHALL stay in fixed_sqrt.
REQ-029 Elaboration SHALL fail on odd W, odd F, F > W or negative E.

Verification (defaults W=12, F=4, E=6, QW=12, QF=8)
REQ-030 a = 64 (4.0), start at t -> valid at t+13, q = 512 (2.0), rem = 0.
REQ-031 a = 32 (2.0) -> q = 362 (1.4140625), rem = 131072 - 131044 = 28.
REQ-032 a = 4095 -> q = 4095, rem = 4095; a = 0 -> valid at t+2, q = 0.
REQ-033 start re-asserted with a = 16 during CALC of a = 64 -> ignored, single valid with q = 512; back-to-back start on the first ready cycle after valid -> accepted.
REQ-034 rst asserted mid-CALC -> no valid, ready = 1 next cycle, q = 0; new start -> correct result.
REQ-035 Random a with SQRT_REM_EN defined and undefined -> q*q <= R < (q+1)^2 against a model, latency fixed at QW+1.
